// File: rtl/sdr_app_cmdq_pkg.sv
// Shared SDRAM application defines: default widths and command-entry layout.
package sdr_app_cmdq_pkg;

   localparam int unsigned SDR_ADDR_WIDTH = 21;
   localparam int unsigned SDR_DATA_WIDTH = 32;
   localparam int unsigned SDR_DM_WIDTH   = 4;
   localparam int unsigned SDR_DEPTH_LOG2 = 4;

   // Command entry layout, MSB first: {we, addr, dm, din}
   typedef struct packed {
      logic                      we;
      logic [SDR_ADDR_WIDTH-1:0] addr;
      logic [SDR_DM_WIDTH-1:0]   dm;
      logic [SDR_DATA_WIDTH-1:0] din;
   } sdr_cmd_t;

   // Width of one packed {we, addr, dm, din} entry for arbitrary field widths
   function automatic int unsigned cmd_entry_width(input int unsigned aw,
                                                   input int unsigned dw,
                                                   input int unsigned mw);
      return 1 + aw + mw + dw;
   endfunction

endpackage

// File: rtl/sdr_cmd_fifo.sv
// Synchronous FIFO with show-ahead head; a write to a full FIFO is accepted
// when a read happens in the same cycle.
module sdr_cmd_fifo #(
   parameter int unsigned WIDTH      = 58,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data_c,
   output logic                  full_c,
   output logic                  empty_c,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  wr_ok_c;
   logic                  rd_ok_c;

   assign full_c    = (level == LVL_W'(DEPTH));
   assign empty_c   = (level == '0);
   assign rd_data_c = mem[rd_ptr];

   // Qualify push/pop against occupancy
   always_comb begin
      rd_ok_c = rd_en & ~empty_c;
      wr_ok_c = wr_en & (~full_c | rd_ok_c);
   end

   // Storage array, no reset needed
   always_ff @(posedge Clk) begin
      if (wr_ok_c) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally modulo depth; level tracks occupancy
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok_c) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (rd_ok_c) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         case ({wr_ok_c, rd_ok_c})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/sdr_app_cmdq.sv
// Application command queue: arbitrates write/read requests into one in-order
// FIFO and presents the head through a valid/ready output register.
module sdr_app_cmdq
   import sdr_app_cmdq_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = SDR_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = SDR_DATA_WIDTH,
   parameter int unsigned DM_WIDTH   = SDR_DM_WIDTH,
   parameter int unsigned DEPTH_LOG2 = SDR_DEPTH_LOG2
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  Sdr_init_done,
   input  logic                  Sdr_init_ref_vld,
   input  logic                  App_wr_en,
   input  logic [ADDR_WIDTH-1:0] App_wr_addr,
   input  logic [DM_WIDTH-1:0]   App_wr_dm,
   input  logic [DATA_WIDTH-1:0] App_wr_din,
   input  logic                  App_rd_en,
   input  logic [ADDR_WIDTH-1:0] App_rd_addr,
   output logic                  Sdr_cmd_vld,
   output logic                  Sdr_cmd_we,
   output logic [ADDR_WIDTH-1:0] Sdr_cmd_addr,
   output logic [DM_WIDTH-1:0]   Sdr_cmd_dm,
   output logic [DATA_WIDTH-1:0] Sdr_cmd_din,
   input  logic                  Sdr_cmd_rdy,
   output logic [DEPTH_LOG2:0]   Q_level,
   output logic                  Q_ovf,
   output logic                  Req_coll
);

   localparam int unsigned ENTRY_W = cmd_entry_width(ADDR_WIDTH, DATA_WIDTH, DM_WIDTH);

   logic [ENTRY_W-1:0] push_entry_c;
   logic [ENTRY_W-1:0] head_entry_c;
   logic               push_c;
   logic               pop_c;
   logic               q_full_c;
   logic               q_empty_c;

   // Request arbitration (write wins a collision) and output-register load condition
   always_comb begin
      push_c       = App_wr_en | App_rd_en;
      push_entry_c = {1'b0, App_rd_addr, {DM_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}};
      if (App_wr_en) push_entry_c = {1'b1, App_wr_addr, App_wr_dm, App_wr_din};
      pop_c = (~Sdr_cmd_vld | Sdr_cmd_rdy) & ~q_empty_c &
              Sdr_init_done & ~Sdr_init_ref_vld;
   end

   sdr_cmd_fifo #(
      .WIDTH      (ENTRY_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .wr_en     (push_c),
      .wr_data   (push_entry_c),
      .rd_en     (pop_c),
      .rd_data_c (head_entry_c),
      .full_c    (q_full_c),
      .empty_c   (q_empty_c),
      .level     (Q_level)
   );

   // Output register: load head when free or handing off, else hold until accepted
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Sdr_cmd_vld  <= 1'b0;
         Sdr_cmd_we   <= 1'b0;
         Sdr_cmd_addr <= '0;
         Sdr_cmd_dm   <= '0;
         Sdr_cmd_din  <= '0;
      end else if (pop_c) begin
         Sdr_cmd_vld  <= 1'b1;
         Sdr_cmd_we   <= head_entry_c[ENTRY_W-1];
         Sdr_cmd_addr <= head_entry_c[ENTRY_W-2 -: ADDR_WIDTH];
         Sdr_cmd_dm   <= head_entry_c[DATA_WIDTH +: DM_WIDTH];
         Sdr_cmd_din  <= head_entry_c[DATA_WIDTH-1:0];
      end else if (Sdr_cmd_rdy) begin
         Sdr_cmd_vld  <= 1'b0;
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Q_ovf    <= 1'b0;
         Req_coll <= 1'b0;
      end else begin
         if (push_c & q_full_c & ~pop_c) Q_ovf    <= 1'b1;
         if (App_wr_en & App_rd_en)      Req_coll <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdr_app_cmdq.sv
// Testbench for sdr_app_cmdq: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_sdr_app_cmdq;

   localparam int AW = 21;
   localparam int DW = 32;
   localparam int MW = 4;
   localparam int DEPTH = 16;

   typedef logic [AW+MW+DW:0] ent_t;

   logic          Clk;
   logic          Rst_n;
   logic          Sdr_init_done;
   logic          Sdr_init_ref_vld;
   logic          App_wr_en;
   logic [AW-1:0] App_wr_addr;
   logic [MW-1:0] App_wr_dm;
   logic [DW-1:0] App_wr_din;
   logic          App_rd_en;
   logic [AW-1:0] App_rd_addr;
   logic          Sdr_cmd_vld;
   logic          Sdr_cmd_we;
   logic [AW-1:0] Sdr_cmd_addr;
   logic [MW-1:0] Sdr_cmd_dm;
   logic [DW-1:0] Sdr_cmd_din;
   logic          Sdr_cmd_rdy;
   logic [4:0]    Q_level;
   logic          Q_ovf;
   logic          Req_coll;

   int checks = 0;
   int errors = 0;

   // Reference model state
   ent_t mq[$];
   ent_t m_issued[$];
   ent_t m_cmd;
   bit   m_vld, m_ovf, m_coll;
   ent_t dut_log[$];

   sdr_app_cmdq dut (
      .Clk              (Clk),
      .Rst_n            (Rst_n),
      .Sdr_init_done    (Sdr_init_done),
      .Sdr_init_ref_vld (Sdr_init_ref_vld),
      .App_wr_en        (App_wr_en),
      .App_wr_addr      (App_wr_addr),
      .App_wr_dm        (App_wr_dm),
      .App_wr_din       (App_wr_din),
      .App_rd_en        (App_rd_en),
      .App_rd_addr      (App_rd_addr),
      .Sdr_cmd_vld      (Sdr_cmd_vld),
      .Sdr_cmd_we       (Sdr_cmd_we),
      .Sdr_cmd_addr     (Sdr_cmd_addr),
      .Sdr_cmd_dm       (Sdr_cmd_dm),
      .Sdr_cmd_din      (Sdr_cmd_din),
      .Sdr_cmd_rdy      (Sdr_cmd_rdy),
      .Q_level          (Q_level),
      .Q_ovf            (Q_ovf),
      .Req_coll         (Req_coll)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic ent_t out_ent();
      return {Sdr_cmd_we, Sdr_cmd_addr, Sdr_cmd_dm, Sdr_cmd_din};
   endfunction

   function automatic ent_t wr_ent(input logic [AW-1:0] a, input logic [MW-1:0] m,
                                   input logic [DW-1:0] d);
      return {1'b1, a, m, d};
   endfunction

   task automatic model_clear();
      mq.delete();
      m_issued.delete();
      m_vld  = 0;
      m_ovf  = 0;
      m_coll = 0;
      m_cmd  = '0;
   endtask

   task automatic set_idle();
      App_wr_en = 0;
      App_rd_en = 0;
   endtask

   // Advance one clock: update the model from the rules, log DUT handshakes
   task automatic tick();
      int   n;
      bit   hs, ld;
      ent_t e;
      n  = mq.size();
      hs = m_vld && Sdr_cmd_rdy;
      ld = (!m_vld || Sdr_cmd_rdy) && n > 0 && Sdr_init_done && !Sdr_init_ref_vld;
      if (Sdr_cmd_vld && Sdr_cmd_rdy) dut_log.push_back(out_ent());
      if (App_wr_en && App_rd_en) m_coll = 1;
      if (App_wr_en) e = wr_ent(App_wr_addr, App_wr_dm, App_wr_din);
      else           e = {1'b0, App_rd_addr, 4'h0, 32'h0};
      if (hs) m_issued.push_back(m_cmd);
      if (ld) begin
         m_cmd = mq.pop_front();
         m_vld = 1;
      end else if (hs) begin
         m_vld = 0;
      end
      if (App_wr_en || App_rd_en) begin
         if (n < DEPTH || ld) mq.push_back(e);
         else                 m_ovf = 1;
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic apply_reset();
      set_idle();
      Rst_n = 0;
      #1;
      model_clear();
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (Sdr_cmd_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b want 0", Sdr_cmd_vld); end
      checks++; if (Sdr_cmd_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", Sdr_cmd_we); end
      checks++; if (Sdr_cmd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", Sdr_cmd_addr); end
      checks++; if (Sdr_cmd_dm !== '0) begin errors++; $display("FAIL reset_dm: got %0h want 0", Sdr_cmd_dm); end
      checks++; if (Sdr_cmd_din !== '0) begin errors++; $display("FAIL reset_din: got %0h want 0", Sdr_cmd_din); end
      checks++; if (Q_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", Q_level); end
      checks++; if (Q_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", Q_ovf); end
      checks++; if (Req_coll !== 1'b0) begin errors++; $display("FAIL reset_coll: got %0b want 0", Req_coll); end
      @(posedge Clk);
      #1;
      Rst_n = 1;
      model_clear();
   endtask

   task automatic test_basic_writes();
      apply_reset();
      dut_log.delete();
      Sdr_init_done = 1;
      Sdr_cmd_rdy   = 1;
      for (int i = 0; i < 4; i++) begin
         App_wr_en   = 1;
         App_wr_addr = AW'(i);
         App_wr_dm   = 4'hF;
         App_wr_din  = DW'(i + 1);
         tick();
         if (i == 0) begin
            checks++; if (Sdr_cmd_vld !== 1'b0) begin errors++; $display("FAIL latency_early: vld got %0b want 0", Sdr_cmd_vld); end
         end
         if (i == 1) begin
            checks++; if (Sdr_cmd_vld !== 1'b1) begin errors++; $display("FAIL latency_2cyc: vld got %0b want 1", Sdr_cmd_vld); end
         end
      end
      set_idle();
      repeat (6) tick();
      checks++; if (dut_log.size() != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", dut_log.size()); end
      for (int i = 0; i < 4 && i < dut_log.size(); i++) begin
         checks++;
         if (dut_log[i] !== wr_ent(AW'(i), 4'hF, DW'(i + 1))) begin
            errors++; $display("FAIL basic_order[%0d]: got %h want %h", i, dut_log[i], wr_ent(AW'(i), 4'hF, DW'(i + 1)));
         end
      end
      checks++; if (Sdr_cmd_vld !== 1'b0) begin errors++; $display("FAIL basic_idle_vld: got %0b want 0", Sdr_cmd_vld); end
   endtask

   task automatic test_overflow();
      ent_t exp[$];
      ent_t e;
      apply_reset();
      dut_log.delete();
      Sdr_init_done = 1;
      Sdr_cmd_rdy   = 0;
      for (int i = 0; i < 17; i++) begin
         App_wr_en   = 1;
         App_wr_addr = AW'($urandom);
         App_wr_dm   = MW'($urandom);
         App_wr_din  = $urandom;
         exp.push_back(wr_ent(App_wr_addr, App_wr_dm, App_wr_din));
         tick();
      end
      checks++; if (Q_level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d want 16", Q_level); end
      checks++; if (Sdr_cmd_vld !== 1'b1) begin errors++; $display("FAIL full_vld: got %0b want 1", Sdr_cmd_vld); end
      checks++; if (out_ent() !== exp[0]) begin errors++; $display("FAIL full_head: got %h want %h", out_ent(), exp[0]); end
      checks++; if (Q_ovf !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %0b want 0", Q_ovf); end
      // Push and pop together on a full queue
      App_wr_addr = AW'($urandom);
      App_wr_din  = $urandom;
      exp.push_back(wr_ent(App_wr_addr, App_wr_dm, App_wr_din));
      Sdr_cmd_rdy = 1;
      tick();
      checks++; if (Q_level !== 5'd16) begin errors++; $display("FAIL simul_level: got %0d want 16", Q_level); end
      checks++; if (Q_ovf !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %0b want 0", Q_ovf); end
      // Push into a full queue with nothing leaving
      Sdr_cmd_rdy = 0;
      App_wr_addr = AW'($urandom);
      tick();
      checks++; if (Q_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b want 1", Q_ovf); end
      checks++; if (Q_level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d want 16", Q_level); end
      set_idle();
      Sdr_cmd_rdy = 1;
      repeat (22) tick();
      checks++; if (dut_log.size() != exp.size()) begin errors++; $display("FAIL ovf_count: got %0d want %0d", dut_log.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < dut_log.size(); i++) begin
         e = exp[i];
         checks++; if (dut_log[i] !== e) begin errors++; $display("FAIL ovf_order[%0d]: got %h want %h", i, dut_log[i], e); end
      end
      checks++; if (Q_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", Q_ovf); end
   endtask

   task automatic test_collision();
      ent_t e;
      apply_reset();
      dut_log.delete();
      Sdr_init_done = 1;
      Sdr_cmd_rdy   = 1;
      App_wr_en   = 1;
      App_wr_addr = AW'(5);
      App_wr_dm   = 4'h3;
      App_wr_din  = $urandom;
      App_rd_en   = 1;
      App_rd_addr = AW'(9);
      e = wr_ent(AW'(5), 4'h3, App_wr_din);
      tick();
      set_idle();
      repeat (5) tick();
      checks++; if (dut_log.size() != 1) begin errors++; $display("FAIL coll_count: got %0d want 1", dut_log.size()); end
      if (dut_log.size() > 0) begin
         checks++; if (dut_log[0] !== e) begin errors++; $display("FAIL coll_cmd: got %h want %h", dut_log[0], e); end
      end
      checks++; if (Req_coll !== 1'b1) begin errors++; $display("FAIL coll_flag: got %0b want 1", Req_coll); end
      checks++; if (Q_ovf !== 1'b0) begin errors++; $display("FAIL coll_ovf: got %0b want 0", Q_ovf); end
   endtask

   task automatic test_refresh();
      ent_t exp[$];
      ent_t e;
      apply_reset();
      dut_log.delete();
      Sdr_init_done = 1;
      Sdr_cmd_rdy   = 0;
      for (int i = 0; i < 4; i++) begin
         App_wr_en   = 1;
         App_wr_addr = AW'(16'h100 + i);
         App_wr_dm   = 4'hA;
         App_wr_din  = $urandom;
         exp.push_back(wr_ent(App_wr_addr, App_wr_dm, App_wr_din));
         tick();
      end
      set_idle();
      tick();
      Sdr_init_ref_vld = 1;
      for (int k = 0; k < 10; k++) begin
         Sdr_cmd_rdy = (k >= 3);
         tick();
         if (k < 3) begin
            checks++; if (Sdr_cmd_vld !== 1'b1 || out_ent() !== exp[0]) begin
               errors++; $display("FAIL ref_hold[%0d]: vld %0b cmd %h want 1 %h", k, Sdr_cmd_vld, out_ent(), exp[0]);
            end
         end else begin
            checks++; if (Sdr_cmd_vld !== 1'b0) begin errors++; $display("FAIL ref_block[%0d]: vld got %0b want 0", k, Sdr_cmd_vld); end
         end
         checks++; if (Q_level !== 5'd3) begin errors++; $display("FAIL ref_level[%0d]: got %0d want 3", k, Q_level); end
      end
      Sdr_init_ref_vld = 0;
      repeat (6) tick();
      checks++; if (dut_log.size() != 4) begin errors++; $display("FAIL ref_count: got %0d want 4", dut_log.size()); end
      for (int i = 0; i < 4 && i < dut_log.size(); i++) begin
         e = exp[i];
         checks++; if (dut_log[i] !== e) begin errors++; $display("FAIL ref_order[%0d]: got %h want %h", i, dut_log[i], e); end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      dut_log.delete();
      Sdr_init_done = 1;
      Sdr_cmd_rdy   = 0;
      for (int i = 0; i < 9; i++) begin
         App_wr_en   = 1;
         App_wr_addr = AW'($urandom);
         App_wr_dm   = 4'hF;
         App_wr_din  = $urandom;
         tick();
      end
      set_idle();
      checks++; if (Q_level !== 5'd8) begin errors++; $display("FAIL mid_level_pre: got %0d want 8", Q_level); end
      #2;
      Rst_n = 0;
      #1;
      checks++; if (Sdr_cmd_vld !== 1'b0) begin errors++; $display("FAIL mid_vld: got %0b want 0", Sdr_cmd_vld); end
      checks++; if (out_ent() !== '0) begin errors++; $display("FAIL mid_payload: got %h want 0", out_ent()); end
      checks++; if (Q_level !== 5'd0) begin errors++; $display("FAIL mid_level: got %0d want 0", Q_level); end
      model_clear();
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1;
      Sdr_cmd_rdy = 1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (Sdr_cmd_vld !== 1'b0) begin errors++; $display("FAIL mid_after[%0d]: vld got %0b want 0", k, Sdr_cmd_vld); end
      end
      checks++; if (dut_log.size() != 0) begin errors++; $display("FAIL mid_issued: got %0d want 0", dut_log.size()); end
   endtask

   task automatic test_random();
      apply_reset();
      dut_log.delete();
      for (int c = 0; c < 600; c++) begin
         App_wr_en        = ($urandom % 3 == 0);
         App_rd_en        = ($urandom % 4 == 0);
         App_wr_addr      = AW'($urandom);
         App_wr_dm        = MW'($urandom);
         App_wr_din       = $urandom;
         App_rd_addr      = AW'($urandom);
         Sdr_cmd_rdy      = (c < 300) ? ($urandom % 10 < 7) : ($urandom % 10 < 2);
         Sdr_init_ref_vld = ($urandom % 12 == 0);
         Sdr_init_done    = ($urandom % 32 != 0);
         tick();
         checks++; if (Sdr_cmd_vld !== m_vld) begin errors++; $display("FAIL rnd_vld@%0d: got %0b want %0b", c, Sdr_cmd_vld, m_vld); end
         if (m_vld) begin
            checks++; if (out_ent() !== m_cmd) begin errors++; $display("FAIL rnd_cmd@%0d: got %h want %h", c, out_ent(), m_cmd); end
         end
         checks++; if (Q_level !== 5'(mq.size())) begin errors++; $display("FAIL rnd_level@%0d: got %0d want %0d", c, Q_level, mq.size()); end
         checks++; if (Q_ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d: got %0b want %0b", c, Q_ovf, m_ovf); end
         checks++; if (Req_coll !== m_coll) begin errors++; $display("FAIL rnd_coll@%0d: got %0b want %0b", c, Req_coll, m_coll); end
      end
      set_idle();
      Sdr_cmd_rdy      = 1;
      Sdr_init_ref_vld = 0;
      Sdr_init_done    = 1;
      repeat (20) tick();
      checks++; if (dut_log.size() != m_issued.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", dut_log.size(), m_issued.size()); end
      for (int i = 0; i < m_issued.size() && i < dut_log.size(); i++) begin
         if (dut_log[i] !== m_issued[i]) begin
            checks++; errors++; $display("FAIL rnd_order[%0d]: got %h want %h", i, dut_log[i], m_issued[i]);
         end else begin
            checks++;
         end
      end
   endtask

   initial begin
      Rst_n            = 0;
      Sdr_init_done    = 0;
      Sdr_init_ref_vld = 0;
      App_wr_en        = 0;
      App_wr_addr      = '0;
      App_wr_dm        = '0;
      App_wr_din       = '0;
      App_rd_en        = 0;
      App_rd_addr      = '0;
      Sdr_cmd_rdy      = 0;
      model_clear();
      test_reset();
      test_basic_writes();
      test_overflow();
      test_collision();
      test_refresh();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sdr_app_cmdq.md
SDR_APP_CMDQ -- requirements
Module: sdr_app_cmdq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 21, SDRAM application address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, application data width.
REQ-003 SHALL have parameter DM_WIDTH, default 4, data-mask width.
REQ-004 SHALL have parameter DEPTH_LOG2, default 4, queue depth 2**DEPTH_LOG2 (16) entries.
REQ-005 SHALL have port Clk  in  1  single clock for the whole block.
REQ-006 SHALL have port Rst_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port Sdr_init_done  in  1  SDRAM initialisation complete; no command issued while low.
REQ-008 SHALL have port Sdr_init_ref_vld  in  1  refresh in progress; no new command launched while high.
REQ-009 SHALL have port App_wr_en  in  1  write request strobe, one entry per high cycle.
REQ-010 SHALL have port App_wr_addr  in  ADDR_WIDTH  write address.
REQ-011 SHALL have port App_wr_dm  in  DM_WIDTH  write byte mask.
REQ-012 SHALL have port App_wr_din  in  DATA_WIDTH  write data.
REQ-013 SHALL have port App_rd_en  in  1  read request strobe.
REQ-014 SHALL have port App_rd_addr  in  ADDR_WIDTH  read address.
REQ-015 SHALL have port Sdr_cmd_vld  out  1  command valid to SDRAM controller.
REQ-016 SHALL have port Sdr_cmd_we  out  1  1 = write, 0 = read.
REQ-017 SHALL have ports Sdr_cmd_addr / Sdr_cmd_dm / Sdr_cmd_din  out  ADDR_WIDTH / DM_WIDTH / DATA_WIDTH  command payload; dm and din are zero for reads.
REQ-018 SHALL have port Sdr_cmd_rdy  in  1  controller accepts the command when high with Sdr_cmd_vld.
REQ-019 SHALL have port Q_level  out  DEPTH_LOG2+1  current queue occupancy.
REQ-020 SHALL have ports Q_ovf and Req_coll  out  1 each  sticky error flags.

Function
REQ-021 Single in-order queue SHALL hold entries {we, addr, dm, din}; commands leave in arrival order.
REQ-022 App_wr_en high and queue not full SHALL enqueue {1, App_wr_addr, App_wr_dm, App_wr_din} at that edge.
REQ-023 App_rd_en high and queue not full SHALL enqueue {0, App_rd_addr, 0, 0}.
REQ-024 App_wr_en and App_rd_en high in the same cycle SHALL enqueue only the write, drop the read, and set Req_coll.
REQ-025 Request arriving while queue full SHALL be dropped and SHALL set Q_ovf; Q_ovf and Req_coll clear only on reset.
REQ-026 Enqueue and dequeue in the same cycle on a full queue SHALL be accepted (occupancy unchanged, no overflow).
REQ-027 Output register SHALL load the queue head when (Sdr_cmd_vld low or handshake completing) and queue non-empty and Sdr_init_done high and Sdr_init_ref_vld low.
REQ-028 Latency: request into empty queue with idle output SHALL produce Sdr_cmd_vld high 2 cycles after the request cycle.
REQ-029 Sdr_cmd_vld and payload SHALL stay stable until Sdr_cmd_vld and Sdr_cmd_rdy are both high; back-to-back issue SHALL sustain one command per cycle.
REQ-030 Sdr_init_ref_vld rising while Sdr_cmd_vld is high SHALL NOT withdraw the pending command.
REQ-031 Q_level SHALL count queued entries only, excluding the output register; read/write pointers SHALL wrap modulo depth.

Reset
REQ-032 Rst_n low SHALL asynchronously clear pointers, Q_level, Sdr_cmd_vld, Sdr_cmd_we, all payload outputs, Q_ovf and Req_coll to 0.
REQ-033 Reset mid-operation SHALL discard all queued and pending commands; no command SHALL issue before 2 cycles after release.

Structure
REQ-034 ADDR_WIDTH/DATA_WIDTH/DM_WIDTH defaults and command-entry field layout SHALL live in the shared SDRAM defines file.
REQ-035 Queue storage SHALL be one sub-module, sdr_cmd_fifo (synchronous FIFO, full/empty/level outputs); arbitration and output register stay in the top.

Verification
REQ-036 Init done, rdy=1, writes to addr 0..3 data 1..4 -> four write commands, same order, vld first seen 2 cycles after first strobe.
REQ-037 Rdy held 0, 17 writes -> Q_level=16, Q_level+output reg hold first 17? no: 16 queued plus 1 in output reg, 18th write sets Q_ovf=1.
REQ-038 Write addr 5 and read addr 9 same cycle -> only write to 5 issued, Req_coll=1.
REQ-039 Sdr_init_ref_vld high 10 cycles with 3 queued -> vld stays low, 3 commands issue after it drops; pending command at refresh onset held.
REQ-040 Rst_n low mid-burst with 8 queued -> all outputs 0 immediately, nothing issued after release.
